setup_controller: RTL and testbench

SETUP_CONTROLLER -- requirements
Module: setup_controller

---
 rtl/setup_controller_pkg.sv | 56 +++++
 rtl/setup_controller_if.sv | 24 ++
 rtl/setup_controller_senha_buffer.sv | 24 ++
 rtl/setup_controller.sv | 145 ++++++++++++++
 tb/tb_setup_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/setup_controller_pkg.sv
// Shared types, key codes and FSM states for the keypad-driven setup controller.
package setup_controller_pkg;

  localparam int SENHA_LEN = 20;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] BLANK     = 4'hF;

  typedef struct packed {
    logic [SENHA_LEN-1:0][3:0] digits;
  } senhaPac_t;

  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [5:0] bip_time;
    logic [5:0] tranca_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
    senhaPac_t  senha_3;
    senhaPac_t  senha_4;
  } setupPac_t;

  typedef enum logic [2:0] {
    IDLE,
    BIP_ON,
    BIP_TIME,
    TRANCA_TIME,
    SENHA,
    DONE
  } state_t;

  // Numeric value of a short (0-2 digit) entry; a lone digit counts as units.
  function automatic logic [6:0] buffer_value(input logic [3:0] tens,
                                              input logic [3:0] units,
                                              input logic [4:0] len);
    logic [6:0] v;
    v = '0;
    if (len == 5'd1)
      v = {3'b000, units};
    else if (len >= 5'd2)
      v = 7'(tens) * 7'd10 + 7'(units);
    return v;
  endfunction

endpackage

// File: rtl/setup_controller_if.sv
// Keypad, configuration and display bundle between the setup controller and its user.
interface setup_controller_if;
  import setup_controller_pkg::*;

  logic       setup_on;
  logic [3:0] digito;
  logic       digito_valido;
  setupPac_t  data_setup_old;
  setupPac_t  data_setup_new;
  bcdPac_t    bcd_out;
  logic       bcd_enable;
  logic       setup_end;

  modport master (
    output setup_on, digito, digito_valido, data_setup_old,
    input  data_setup_new, bcd_out, bcd_enable, setup_end
  );

  modport slave (
    input  setup_on, digito, digito_valido, data_setup_old,
    output data_setup_new, bcd_out, bcd_enable, setup_end
  );

endinterface

// File: rtl/setup_controller_senha_buffer.sv
// Entry buffer: newest digit enters at index 0, older digits shift up, unused slots stay blank.
module senha_buffer
  import setup_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_in,
  input  logic [3:0] digit_in,
  output senhaPac_t  digits,
  output logic [4:0] length
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digits <= {SENHA_LEN{BLANK}};
      length <= '0;
    end else if (shift_in && (length < 5'(SENHA_LEN))) begin
      digits.digits <= {digits.digits[SENHA_LEN-2:0], digit_in};
      length        <= length + 5'd1;
    end
  end

endmodule

// File: rtl/setup_controller.sv
// Setup session FSM: walks bip, times and five passwords, editing a copy of the live config.
module setup_controller
  import setup_controller_pkg::*;
#(
  parameter int TIME_MIN  = 5,
  parameter int TIME_MAX  = 60,
  parameter int SENHA_MIN = 4
) (
  input logic               clk,
  input logic               rst,
  setup_controller_if.slave bus
);

  localparam logic [6:0] T_MIN   = 7'(TIME_MIN);
  localparam logic [6:0] T_MAX   = 7'(TIME_MAX);
  localparam logic [4:0] PSW_MIN = 5'(SENHA_MIN);

  state_t     state, state_nxt;
  logic [2:0] k, k_nxt;
  setupPac_t  cfg, cfg_nxt;
  logic       buf_clear, buf_shift;
  senhaPac_t  buf_digits;
  logic [4:0] buf_len, buf_cap;
  logic [6:0] buf_val, time_val, disp_val;
  logic       active;

  senha_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear),
    .shift_in (buf_shift),
    .digit_in (bus.digito),
    .digits   (buf_digits),
    .length   (buf_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      cfg   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      cfg   <= cfg_nxt;
    end
  end

  assign active   = (state != IDLE) && (state != DONE);
  assign buf_val  = buffer_value(buf_digits.digits[1], buf_digits.digits[0], buf_len);
  assign time_val = (buf_val < T_MIN) ? T_MIN : ((buf_val > T_MAX) ? T_MAX : buf_val);

  always_comb begin
    case (state)
      BIP_ON:                buf_cap = 5'd1;
      BIP_TIME, TRANCA_TIME: buf_cap = 5'd2;
      default:               buf_cap = 5'(SENHA_LEN);
    endcase
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cfg_nxt   = cfg;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    case (state)
      IDLE: begin
        if (bus.setup_on) begin
          cfg_nxt   = bus.data_setup_old;
          buf_clear = 1'b1;
          k_nxt     = '0;
          state_nxt = BIP_ON;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        if (bus.digito_valido) begin
          if (bus.digito <= 4'd9) begin
            buf_shift = (buf_len < buf_cap);
          end else if (bus.digito == KEY_CLEAR) begin
            buf_clear = 1'b1;
            if (buf_len == 5'd0) begin
              cfg_nxt   = bus.data_setup_old;
              state_nxt = DONE;
            end
          end else if (bus.digito == KEY_ENTER) begin
            buf_clear = 1'b1;
            // A too-short password is rejected in place: buffer wiped, field kept.
            if (!(state == SENHA && buf_len != 5'd0 && buf_len < PSW_MIN)) begin
              case (state)
                BIP_ON: begin
                  if (buf_len != 5'd0) cfg_nxt.bip_status = (buf_val != 7'd0);
                  state_nxt = BIP_TIME;
                end
                BIP_TIME: begin
                  if (buf_len != 5'd0) cfg_nxt.bip_time = time_val[5:0];
                  state_nxt = TRANCA_TIME;
                end
                TRANCA_TIME: begin
                  if (buf_len != 5'd0) cfg_nxt.tranca_aut_time = time_val[5:0];
                  k_nxt     = '0;
                  state_nxt = SENHA;
                end
                default: begin
                  if (buf_len != 5'd0) begin
                    case (k)
                      3'd0:    cfg_nxt.senha_master = buf_digits;
                      3'd1:    cfg_nxt.senha_1      = buf_digits;
                      3'd2:    cfg_nxt.senha_2      = buf_digits;
                      3'd3:    cfg_nxt.senha_3      = buf_digits;
                      default: cfg_nxt.senha_4      = buf_digits;
                    endcase
                  end
                  if (k == 3'd4) state_nxt = DONE;
                  else           k_nxt     = k + 3'd1;
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.bcd_out = {6{BLANK}};
    disp_val    = (state == SENHA) ? {2'b00, buf_len} : buf_val;
    if (active) begin
      case (state)
        BIP_ON:      bus.bcd_out.BCD5 = 4'd1;
        BIP_TIME:    bus.bcd_out.BCD5 = 4'd2;
        TRANCA_TIME: bus.bcd_out.BCD5 = 4'd3;
        default:     bus.bcd_out.BCD5 = 4'd4 + {1'b0, k};
      endcase
      bus.bcd_out.BCD1 = 4'(disp_val / 7'd10);
      bus.bcd_out.BCD0 = 4'(disp_val % 7'd10);
    end
  end

  assign bus.bcd_enable     = active;
  assign bus.setup_end      = (state == DONE);
  assign bus.data_setup_new = cfg;

endmodule

// File: tb/tb_setup_controller.sv
// Directed bench for setup_controller: field entry, clamping, password rules, abort and reset.
module tb_setup_controller;
  import setup_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  setupPac_t old_cfg, exp_cfg;

  setup_controller_if bus ();

  setup_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] key);
    @(negedge clk);
    bus.digito        = key;
    bus.digito_valido = 1'b1;
    @(negedge clk);
    bus.digito_valido = 1'b0;
  endtask

  task automatic startSession();
    @(negedge clk);
    bus.setup_on = 1'b1;
    @(negedge clk);
    bus.setup_on = 1'b0;
  endtask

  task automatic checkBcd(input string tag, input logic [23:0] expected);
    checkOutput(tag, 512'(bus.bcd_out), 512'(expected));
  endtask

  task automatic checkCfg(input string tag, input setupPac_t expected);
    checkOutput(tag, 512'(bus.data_setup_new), 512'(expected));
  endtask

  initial begin
    old_cfg                     = '0;
    old_cfg.bip_time            = 6'd10;
    old_cfg.tranca_aut_time     = 6'd20;
    old_cfg.senha_master.digits = 80'hFFFF_FFFF_FFFF_FFFF_9876;
    old_cfg.senha_1.digits      = 80'hFFFF_FFFF_FFFF_FFFF_5555;
    old_cfg.senha_2.digits      = {20{4'hF}};
    old_cfg.senha_3.digits      = {20{4'hF}};
    old_cfg.senha_4.digits      = {20{4'hF}};

    // Reset held together with setup_on and a key: reset must win.
    bus.data_setup_old = old_cfg;
    bus.setup_on       = 1'b1;
    bus.digito         = 4'd1;
    bus.digito_valido  = 1'b1;
    repeat (2) @(negedge clk);
    rst               = 1'b0;
    bus.setup_on      = 1'b0;
    bus.digito_valido = 1'b0;
    checkOutput("rst_cfg", 512'(bus.data_setup_new), 512'd0);
    checkBcd("rst_bcd", 24'hFFFFFF);
    checkOutput("rst_enable", 512'(bus.bcd_enable), 512'd0);
    checkOutput("rst_end", 512'(bus.setup_end), 512'd0);

    // Session 1: bip/time entry with clamping, ignored keys, short password, overflow, reset.
    startSession();
    checkOutput("s1_enable", 512'(bus.bcd_enable), 512'd1);
    checkCfg("s1_load", old_cfg);
    checkBcd("s1_bcd_start", 24'h1FFF00);
    applyStimulus(4'd1);
    checkBcd("s1_bcd_bip1", 24'h1FFF01);
    applyStimulus(4'hC);
    checkBcd("s1_ignore_c", 24'h1FFF01);
    startSession();
    checkBcd("s1_ignore_setup_on", 24'h1FFF01);
    applyStimulus(KEY_ENTER);
    checkOutput("s1_bip_status", 512'(bus.data_setup_new.bip_status), 512'd1);
    checkBcd("s1_bcd_field2", 24'h2FFF00);
    applyStimulus(4'd3);
    applyStimulus(4'd0);
    checkBcd("s1_bcd_30", 24'h2FFF30);
    applyStimulus(KEY_ENTER);
    checkOutput("s1_bip_time", 512'(bus.data_setup_new.bip_time), 512'd30);
    applyStimulus(4'd9);
    applyStimulus(4'd9);
    applyStimulus(4'd7);
    checkBcd("s1_time_full", 24'h3FFF99);
    applyStimulus(KEY_ENTER);
    checkOutput("s1_tranca_clamp", 512'(bus.data_setup_new.tranca_aut_time), 512'd60);
    checkBcd("s1_bcd_field4", 24'h4FFF00);
    applyStimulus(KEY_ENTER);
    checkBcd("s1_bcd_field5", 24'h5FFF00);
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    checkBcd("s1_len2", 24'h5FFF02);
    applyStimulus(KEY_ENTER);
    checkBcd("s1_short_stay", 24'h5FFF00);
    checkOutput("s1_short_nowrite", 512'(bus.data_setup_new.senha_1), 512'(old_cfg.senha_1));
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'd4);
    applyStimulus(KEY_ENTER);
    checkOutput("s1_senha1", 512'(bus.data_setup_new.senha_1),
                512'(80'hFFFF_FFFF_FFFF_FFFF_1234));
    checkBcd("s1_bcd_field6", 24'h6FFF00);
    for (int i = 0; i < 21; i++) applyStimulus(4'(i % 10));
    checkBcd("s1_len20", 24'h6FFF20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("s1_rst_cfg", 512'(bus.data_setup_new), 512'd0);
    checkBcd("s1_rst_bcd", 24'hFFFFFF);
    checkOutput("s1_rst_enable", 512'(bus.bcd_enable), 512'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("s1_rst_no_end", 512'(bus.setup_end), 512'd0);
      @(negedge clk);
    end

    // Session 2: low clamp, full 20-digit master password with 21st dropped, normal finish.
    exp_cfg                     = old_cfg;
    exp_cfg.bip_time            = 6'd5;
    exp_cfg.senha_master.digits = 80'h1234_5678_9012_3456_7890;
    startSession();
    applyStimulus(KEY_ENTER);
    applyStimulus(4'd3);
    applyStimulus(KEY_ENTER);
    checkOutput("s2_time_low_clamp", 512'(bus.data_setup_new.bip_time), 512'd5);
    applyStimulus(KEY_ENTER);
    for (int i = 1; i <= 20; i++) applyStimulus(4'(i % 10));
    applyStimulus(4'd7);
    checkBcd("s2_len20", 24'h4FFF20);
    applyStimulus(KEY_ENTER);
    checkOutput("s2_master", 512'(bus.data_setup_new.senha_master),
                512'(exp_cfg.senha_master));
    repeat (4) applyStimulus(KEY_ENTER);
    checkOutput("s2_end_pulse", 512'(bus.setup_end), 512'd1);
    checkCfg("s2_cfg", exp_cfg);
    checkBcd("s2_done_bcd", 24'hFFFFFF);
    @(negedge clk);
    checkOutput("s2_end_drop", 512'(bus.setup_end), 512'd0);
    checkCfg("s2_hold", exp_cfg);

    // Keys while idle do nothing.
    applyStimulus(4'd5);
    checkOutput("idle_enable", 512'(bus.bcd_enable), 512'd0);
    checkCfg("idle_hold", exp_cfg);

    // Session 3: eight empty enters keep everything.
    startSession();
    for (int i = 0; i < 7; i++) applyStimulus(KEY_ENTER);
    checkOutput("s3_no_end_yet", 512'(bus.setup_end), 512'd0);
    applyStimulus(KEY_ENTER);
    checkOutput("s3_end_pulse", 512'(bus.setup_end), 512'd1);
    checkCfg("s3_cfg", old_cfg);
    @(negedge clk);
    checkOutput("s3_end_drop", 512'(bus.setup_end), 512'd0);

    // Session 4: edit then abort with double clear.
    startSession();
    applyStimulus(4'd7);
    applyStimulus(KEY_ENTER);
    checkOutput("s4_bip_gt1", 512'(bus.data_setup_new.bip_status), 512'd1);
    applyStimulus(4'd4);
    checkBcd("s4_bcd_4", 24'h2FFF04);
    applyStimulus(KEY_CLEAR);
    checkBcd("s4_clear_buf", 24'h2FFF00);
    checkOutput("s4_still_active", 512'(bus.setup_end), 512'd0);
    applyStimulus(KEY_CLEAR);
    checkOutput("s4_abort_end", 512'(bus.setup_end), 512'd1);
    checkCfg("s4_abort_cfg", old_cfg);
    @(negedge clk);
    checkOutput("s4_end_drop", 512'(bus.setup_end), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
